// File: rtl/scan_decoder_if.sv
// Handshake-free control/decode bundle between a scan controller and scan_decoder.
// Master drives enable/mode/select/dwell; slave returns the one-hot decode, index and wrap pulse.
interface scan_decoder_if #(
  parameter int SEL_W = 4,
  parameter int DW_W  = 8
);
  localparam int N = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [DW_W-1:0]  dwell;
  logic [N-1:0]     f;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (output en, mode, sel, dwell, input f, idx, wrap);
  modport slave  (input en, mode, sel, dwell, output f, idx, wrap);
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct and auto-scan modes; outputs lag inputs by one clk edge.
// No backpressure: en=0 blanks f and freezes the index/dwell counters until re-enabled.
module scan_decoder #(
  parameter int SEL_W = 4,
  parameter int DW_W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_decoder_if.slave bus
);
  localparam int N = 2 ** SEL_W;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SEL_W-1:0] r_idx;
  logic [DW_W-1:0]  r_dcnt;
  logic [N-1:0]     r_f;
  logic             r_wrap;
  logic             w_entry;
  logic             w_advance;
  logic [SEL_W-1:0] w_idx_inc;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] code);
    logic [N-1:0] v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  assign w_idx_inc = r_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Any arrival in SCAN from another state is a fresh entry; a frozen scan never resumes.
  always_comb begin
    w_next    = r_state;
    w_entry   = 1'b0;
    w_advance = 1'b0;
    if (!bus.en) begin
      w_next = IDLE;
    end else if (!bus.mode) begin
      w_next = DIRECT;
    end else begin
      w_next = SCAN;
      if (r_state != SCAN)          w_entry   = 1'b1;
      else if (r_dcnt >= bus.dwell) w_advance = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_dcnt <= '0;
      r_f    <= '0;
      r_wrap <= 1'b0;
    end else if (!bus.en) begin
      r_f    <= '0;
      r_wrap <= 1'b0;
    end else if (!bus.mode || w_entry) begin
      r_idx  <= bus.sel;
      r_dcnt <= '0;
      r_f    <= onehot(bus.sel);
      r_wrap <= 1'b0;
    end else if (w_advance) begin
      r_idx  <= w_idx_inc;
      r_dcnt <= '0;
      r_f    <= onehot(w_idx_inc);
      r_wrap <= (r_idx == SEL_W'(N - 1));
    end else begin
      r_dcnt <= r_dcnt + 1'b1;
      r_wrap <= 1'b0;
    end
  end

  assign bus.f    = r_f;
  assign bus.idx  = r_idx;
  assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder at SEL_W=3: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of the decode/scan rules.
module tb_scan_decoder;
  localparam int SEL_W = 3;
  localparam int DW_W  = 8;
  localparam int N     = 2 ** SEL_W;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scan_decoder_if #(.SEL_W(SEL_W), .DW_W(DW_W)) bus ();

  scan_decoder #(.SEL_W(SEL_W), .DW_W(DW_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks whether a scan is running, the current index and how long it has been held.
  bit scanning = 0;
  bit m_valid  = 0;
  int m_idx    = 0;
  int m_held   = 0;
  int m_f      = 0;
  int m_wrap   = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      scanning = 0; m_idx = 0; m_held = 0; m_f = 0; m_wrap = 0; m_valid = 1;
    end else if (!bus.en) begin
      scanning = 0; m_f = 0; m_wrap = 0;
    end else if (!bus.mode || !scanning) begin
      scanning = bus.mode;
      m_idx = int'(bus.sel); m_held = 0; m_f = 1 << m_idx; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (m_held < int'(bus.dwell)) m_held++;
      else begin
        m_held = 0;
        m_idx  = (m_idx + 1) % N;
        m_wrap = (m_idx == 0);
      end
      m_f = 1 << m_idx;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_f",    32'(bus.f),    32'(m_f));
      check("model_idx",  32'(bus.idx),  32'(m_idx));
      check("model_wrap", 32'(bus.wrap), 32'(m_wrap));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan_until(input int target);
    int n;
    n = 0;
    while (int'(bus.idx) != target && n < 64) begin
      tick(1);
      n++;
    end
    check("scan_reach_idx", 32'(bus.idx), 32'(target));
  endtask

  logic [7:0] tab [8];
  int wraps;

  initial begin
    tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst_n = 1'b0; bus.en = 1'b0; bus.mode = 1'b0; bus.sel = '0; bus.dwell = '0;
    tick(2);
    check("reset_f", 32'(bus.f), 32'h0);
    check("reset_idx", 32'(bus.idx), 32'h0);
    check("reset_wrap", 32'(bus.wrap), 32'h0);
    rst_n = 1'b1;

    // Direct sweep
    bus.en = 1'b1; bus.mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.sel = 3'(i);
      tick(1);
      check("direct_f", 32'(bus.f), 32'(tab[i]));
      check("direct_idx", 32'(bus.idx), 32'(i));
      tick(1);
    end

    // Blanking
    bus.en = 1'b0; bus.sel = 3'd2; bus.mode = 1'b1;
    tick(1);
    check("blank_f", 32'(bus.f), 32'h0);
    check("blank_idx", 32'(bus.idx), 32'd7);

    // Scan dwell=0 from 6
    bus.en = 1'b1; bus.mode = 1'b1; bus.dwell = '0; bus.sel = 3'd6;
    tick(1);
    check("scan0_f0", 32'(bus.f), 32'h40);
    bus.sel = 3'd3;
    tick(1);
    check("scan0_f1", 32'(bus.f), 32'h80);
    check("scan0_wrap1", 32'(bus.wrap), 32'h0);
    tick(1);
    check("scan0_f2", 32'(bus.f), 32'h01);
    check("scan0_wrap2", 32'(bus.wrap), 32'h1);
    tick(1);
    check("scan0_idx3", 32'(bus.idx), 32'd1);
    check("scan0_wrap3", 32'(bus.wrap), 32'h0);

    // Scan dwell=2 from 0
    bus.mode = 1'b0; tick(1);
    bus.mode = 1'b1; bus.sel = 3'd0; bus.dwell = 8'd2;
    tick(1);
    check("scan2_entry_wrap", 32'(bus.wrap), 32'h0);
    wraps = 0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 2) check("scan2_hold_01", 32'(bus.f), 32'h01);
      if (c == 3) check("scan2_f_02", 32'(bus.f), 32'h01);
      tick(1);
      if (c == 3 || c == 5) check("scan2_hold_02", 32'(bus.f), 32'h02);
      if (bus.wrap) wraps++;
    end
    check("scan2_idx24", 32'(bus.idx), 32'd0);
    check("scan2_wraps", 32'(wraps), 32'd1);

    // Reset mid-scan
    bus.dwell = '0;
    scan_until(5);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_f", 32'(bus.f), 32'h0);
    check("rst_mid_idx", 32'(bus.idx), 32'h0);
    rst_n = 1'b1; bus.sel = 3'd3;
    tick(1);
    check("rst_reentry_f", 32'(bus.f), 32'h08);

    // en re-entry and dwell reduction
    bus.sel = 3'd0;
    scan_until(3);
    bus.en = 1'b0; bus.sel = 3'd1; bus.dwell = 8'd5;
    tick(2);
    check("freeze_idx", 32'(bus.idx), 32'd3);
    bus.en = 1'b1;
    tick(1);
    check("reentry_f", 32'(bus.f), 32'h02);
    check("reentry_idx", 32'(bus.idx), 32'd1);
    tick(3);
    check("dwell_hold_idx", 32'(bus.idx), 32'd1);
    bus.dwell = 8'd1;
    tick(1);
    check("dwell_cut_idx", 32'(bus.idx), 32'd2);

    // Mode toggle restarts scan at current sel
    bus.mode = 1'b0; bus.sel = 3'd4; tick(1);
    bus.mode = 1'b1; bus.sel = 3'd5; tick(1);
    check("toggle_idx", 32'(bus.idx), 32'd5);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 149) != 0);
      bus.en   = ($urandom_range(0, 11) != 0);
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      bus.sel  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) bus.dwell = 8'($urandom_range(0, 4));
      tick(1);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 The block SHALL have parameter SEL_W, default 4, meaning the select width; output count N = 2**SEL_W, and SEL_W SHALL be legal from 2 to 6.
REQ-002 The block SHALL have parameter DW_W, default 8, meaning the dwell counter width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, a synchronous, active-low reset sampled on the clk rising edge.
REQ-005 The block SHALL have port en, input, 1 bit, a cascade enable; when low, the outputs are blanked and all state is frozen.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = direct decode, 1 = auto-scan.
REQ-007 The block SHALL have port sel, input, SEL_W bits: the decoded code in direct mode, and the start index on scan entry.
REQ-008 The block SHALL have port dwell, input, DW_W bits: each index is held for dwell+1 cycles in scan mode.
REQ-009 The block SHALL have port f, output, N bits: the registered one-hot decode, all zero when inactive.
REQ-010 The block SHALL have port idx, output, SEL_W bits: the index currently driven on f.
REQ-011 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse when the scan index rolls from N-1 to 0.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, DIRECT and SCAN, evaluated each clk edge.
REQ-013 Transitions SHALL be:
- any state with en=0 -> IDLE;
- en=1, mode=0 -> DIRECT;
- en=1, mode=1, from IDLE or DIRECT -> SCAN, with scan entry;
- SCAN with en=1, mode=1 -> stays in SCAN.
REQ-014 On scan entry the block SHALL:
- load the index counter with sel;
- clear the dwell counter;
- drive f = onehot(sel) and idx = sel on that same edge.
REQ-015 On entry to IDLE caused by en=0, the block SHALL retain the index and dwell counters and SHALL NOT alter them.
REQ-016 A return from IDLE to SCAN SHALL be treated as a scan entry, so the index counter reloads from sel; a frozen scan is not resumed.
REQ-017 In DIRECT, f SHALL equal onehot(sel) and idx SHALL equal sel, with 1-cycle latency from sel.
REQ-018 In DIRECT, the dwell counter SHALL be held at 0 and wrap SHALL be 0.
REQ-019 In SCAN, on each edge:
- if dwell_cnt < dwell, then dwell_cnt increments and the index holds;
- otherwise dwell_cnt clears to 0 and the index advances by 1, modulo N.
REQ-020 f and idx SHALL update on the same edge that the index advances.
REQ-021 wrap SHALL be 1 for exactly the cycle in which idx changes from N-1 to 0 in SCAN, and 0 otherwise.
REQ-022 A scan entry with sel=0 SHALL NOT assert wrap.
REQ-023 With dwell=0, the index SHALL advance every cycle.
REQ-024 A dwell change mid-scan SHALL take effect at the next compare; if dwell_cnt is already >= the new dwell, the index SHALL advance on the next edge.
REQ-025 In IDLE, f SHALL be all zero and wrap SHALL be 0, on the edge after en falls, and idx SHALL hold its last value.
REQ-026 f SHALL be one-hot in DIRECT and SCAN and all-zero in IDLE; no other pattern is legal.
REQ-027 A mode toggle 1->0->1 SHALL restart the scan from the current sel.
REQ-028 A mode change SHALL take effect on the first edge at which it is sampled.

Reset
REQ-029 When rst_n=0 at a clk edge, the block SHALL set:
- state = IDLE;
- f = 0, idx = 0, wrap = 0;
- index counter = 0, dwell counter = 0.
REQ-030 Reset SHALL take priority over en, mode and all other inputs.
REQ-031 A reset asserted mid-scan SHALL abort the scan within that same edge.
REQ-032 After rst_n rises, the first active edge SHALL follow REQ-013 with no extra cycle of latency.

Verification
REQ-033 A bench SHALL cover the scenarios below using SEL_W=3:
- Direct sweep: en=1, mode=0, sel=0..7 with each value held for 2 cycles -> f = 8'h01, 02, 04 ... 80, each appearing 1 cycle after sel; idx = sel; wrap = 0.
- Blanking: en=0 with any sel or mode -> f = 8'h00 on the next edge; idx holds; wrap = 0.
- Scan, dwell=0, sel=6: idx = 6, 7, 0, 1; f = 8'h40, 80, 01, 02; wrap = 1 only in the idx=0 cycle.
- Scan, dwell=2, sel=0: each idx is held for 3 cycles; f = 8'h01 for 3 cycles, then 8'h02 for 3; after 24 cycles idx = 0 with a single wrap pulse.
- Reset mid-scan: rst_n=0 for 1 cycle at idx=5 -> f = 0, idx = 0, wrap = 0; re-entry then restarts at sel.
- Mode/en re-entry: scan to idx=3, set en=0 for 2 cycles with sel=1, then en=1 -> f = 8'h02 and idx = 1; dwell reduced from 5 to 1 when dwell_cnt = 3 -> advance on the next edge.
